buf_arbiter: RTL and testbench

BUF_ARBITER -- requirements
Module: buf_arbiter

---
 rtl/buf_arbiter.sv | 163 ++++++++++++++++
 tb/tb_buf_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/buf_arbiter.sv
// buf_arbiter: arbitrates N_REQ requesters onto a single shared-buffer port and
// tracks the buffer occupancy.
// Each access runs IDLE -> WAIT (granted, waiting for check) -> RW (one-cycle
// strobe) -> IDLE, so IDLE is always visited between grants.
// Optional feature: define ROUND_ROBIN_EN for round-robin arbitration. Without
// it, arbitration is fixed priority and the lowest index wins.
module buf_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         wr,
  input  logic                     check,
  output logic [N_REQ-1:0]         grant,
  output logic                     gnt_wr,
  output logic                     valid,
  output logic                     count_pointer,
  output logic [N_REQ-1:0]         done,
  output logic [$clog2(DEPTH):0]   occ,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned OccW = $clog2(DEPTH) + 1;
  localparam logic [OccW-1:0] OccMax = OccW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StRw   = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] win_q, win_d;
  logic            wr_q, wr_d;
  logic [OccW-1:0] occ_q, occ_d;

  // Outputs are registered and derived from the next state, so they are a pure
  // function of the registered state.
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             gnt_wr_q, gnt_wr_d;
  logic             valid_q, valid_d;
  logic [N_REQ-1:0] done_q, done_d;

  logic             full_w, empty_w;
  logic [N_REQ-1:0] elig;
  logic             found;
  logic [IdxW-1:0]  pick;
  logic [IdxW-1:0]  start_idx;

  assign full_w  = (occ_q == OccMax);
  assign empty_w = (occ_q == '0);

`ifdef ROUND_ROBIN_EN
  logic [IdxW-1:0] ptr_q, ptr_d;

  assign start_idx = ptr_q;

  // Pointer moves past the winner only on completion; withdrawal leaves it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StRw) begin
      ptr_d = (32'(win_q) == N_REQ - 1) ? '0 : win_q + 1'b1;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  assign start_idx = '0;
`endif

  // A requester is eligible unless its operation would overflow or underflow.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      elig[i] = req[i] && !(wr[i] && full_w) && !(!wr[i] && empty_w);
    end
  end

  // First eligible requester, searching upward from start_idx with wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && elig[IdxW'((32'(start_idx) + k) % N_REQ)]) begin
        found = 1'b1;
        pick  = IdxW'((32'(start_idx) + k) % N_REQ);
      end
    end
  end

  // Next-state, occupancy and registered-output computation.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    wr_d    = wr_q;
    occ_d   = occ_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StWait;
          win_d   = pick;
          wr_d    = wr[pick];
        end
      end
      StWait: begin
        // Withdrawal wins over check.
        if (!req[win_q])  state_d = StIdle;
        else if (check)   state_d = StRw;
      end
      StRw: begin
        state_d = StIdle;
        if (wr_q && (occ_q != OccMax))      occ_d = occ_q + 1'b1;
        else if (!wr_q && (occ_q != '0))    occ_d = occ_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase

    grant_d  = (state_d != StIdle) ? (N_REQ'(1) << win_d) : '0;
    gnt_wr_d = (state_d != StIdle) && wr_d;
    valid_d  = (state_d == StRw);
    done_d   = valid_d ? (N_REQ'(1) << win_d) : '0;
  end

  // State and output registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      win_q    <= '0;
      wr_q     <= 1'b0;
      occ_q    <= '0;
      grant_q  <= '0;
      gnt_wr_q <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      wr_q     <= wr_d;
      occ_q    <= occ_d;
      grant_q  <= grant_d;
      gnt_wr_q <= gnt_wr_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign grant         = grant_q;
  assign gnt_wr        = gnt_wr_q;
  assign valid         = valid_q;
  assign count_pointer = valid_q;
  assign done          = done_q;
  assign occ           = occ_q;
  assign full          = full_w;
  assign empty         = empty_w;

endmodule

// File: tb/tb_buf_arbiter.sv
// Scoreboard bench for buf_arbiter (N_REQ=4, DEPTH=16). Stimulus pushes the
// expected grant/strobe events; a negedge monitor pops and compares them.
module tb_buf_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] wr;
  logic       check;
  logic [3:0] grant;
  logic       gnt_wr;
  logic       valid;
  logic       count_pointer;
  logic [3:0] done;
  logic [4:0] occ;
  logic       full;
  logic       empty;

  buf_arbiter #(
    .N_REQ(4),
    .DEPTH(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .wr           (wr),
    .check        (check),
    .grant        (grant),
    .gnt_wr       (gnt_wr),
    .valid        (valid),
    .count_pointer(count_pointer),
    .done         (done),
    .occ          (occ),
    .full         (full),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  bit         mon_en   = 1'b0;
  logic [3:0] prev_g   = 4'b0;
  // Entry: {is_strobe, onehot requester, wr (grant) or 1 (strobe)}
  logic [5:0] sb_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'(1 << i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_grant(input int i, input logic w);
    sb_q.push_back({1'b0, oh(i), w});
  endtask

  task automatic push_strobe(input int i);
    sb_q.push_back({1'b1, oh(i), 1'b1});
  endtask

  task automatic mon_event(input string name, input logic [5:0] act);
    logic [5:0] exp;
    if (sb_q.size() == 0) begin
      chk({name, "_unexpected"}, int'(act), 0);
    end else begin
      exp = sb_q.pop_front();
      chk(name, int'(act), int'(exp));
    end
  endtask

  // Monitor: a fresh grant and every strobe cycle are scoreboard events.
  always @(negedge clk) begin
    if (mon_en) begin
      if (grant != 4'b0 && prev_g == 4'b0) mon_event("grant", {1'b0, grant, gnt_wr});
      if (valid) mon_event("strobe", {1'b1, done, count_pointer && (grant == done)});
    end
    prev_g <= grant;
  end

  // One complete access by requester i; req is dropped when done is seen.
  task automatic access(input int i, input logic w);
    bit seen;
    seen = 1'b0;
    push_grant(i, w);
    push_strobe(i);
    req[i] = 1'b1;
    wr[i]  = w;
    check  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done[i]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("access_timeout", 0, 1);
    req[i] = 1'b0;
    wr[i]  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[5];
    int cnt;
    int bad;
    bit seen;

    rst = 1'b1; req = 4'b0; wr = 4'b0; check = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    mon_en = 1'b1;

    chk("rst_grant", grant, 0);
    chk("rst_strobes", {valid, count_pointer, done}, 0);
    chk("rst_occ", occ, 0);
    chk("rst_empty_full", {empty, full}, 2'b10);

    // First write: grant in cycle 2, strobe in cycle 3.
    push_grant(0, 1'b1);
    push_strobe(0);
    req = 4'b0001; wr = 4'b0001; check = 1'b1;
    tick();
    chk("c2_grant", {grant, gnt_wr, valid}, 6'b000110);
    tick();
    chk("c3_strobe", {valid, count_pointer, done}, 6'b110001);
    req = 4'b0; wr = 4'b0;
    tick();
    chk("first_occ", occ, 1);

    // Fill to DEPTH.
    for (int n = 0; n < 15; n++) access(0, 1'b1);
    tick();
    chk("fill_occ", occ, 16);
    chk("fill_full_empty", {full, empty}, 2'b10);

    // Write blocked while full; concurrent read from requester 2 wins.
    push_grant(2, 1'b0);
    push_strobe(2);
    req = 4'b0101; wr = 4'b0001; check = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done[2]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("full_read_timeout", 0, 1);
    req = 4'b0; wr = 4'b0;
    tick();
    chk("after_full_read_occ", occ, 15);

    // Drain to empty.
    for (int n = 0; n < 15; n++) access(1, 1'b0);
    tick();
    chk("drain_occ", occ, 0);
    chk("drain_empty_full", {empty, full}, 2'b10);

    // All four request writes; order depends on arbitration mode.
    do_reset();
`ifdef ROUND_ROBIN_EN
    order = '{0, 1, 2, 3, 0};
`else
    order = '{0, 0, 0, 0, 0};
`endif
    foreach (order[k]) begin
      push_grant(order[k], 1'b1);
      push_strobe(order[k]);
    end
    req = 4'b1111; wr = 4'b1111; check = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done != 4'b0) cnt++;
      if (cnt == 5) break;
    end
    req = 4'b0; wr = 4'b0;
    chk("arb_done_count", cnt, 5);
    tick();
    chk("arb_occ", occ, 5);

    // Grant held with check=0, then withdrawn; requester 2 served next.
    push_grant(1, 1'b0);
    req = 4'b0110; wr = 4'b0000; check = 1'b0;
    tick();
    chk("wait_grant", {grant, gnt_wr}, 5'b00100);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (grant != 4'b0010 || valid) bad++;
    end
    chk("wait_hold", bad, 0);
    push_grant(2, 1'b0);
    push_strobe(2);
    req = 4'b0100; check = 1'b1;
    tick();
    chk("withdraw_idle", {grant, valid, done}, 0);
    chk("withdraw_occ", occ, 5);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done[2]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("withdraw_next_timeout", 0, 1);
    req = 4'b0;
    tick();
    chk("withdraw_next_occ", occ, 4);

    // Read while empty gets no grant.
    do_reset();
    req = 4'b0010; wr = 4'b0000; check = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (grant != 4'b0) seen = 1'b1;
    end
    chk("empty_read_no_grant", seen, 0);
    req = 4'b0;

    // Reset asserted during RW.
    push_grant(3, 1'b1);
    push_strobe(3);
    req = 4'b1000; wr = 4'b1000; check = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("rw_reset_timeout", 0, 1);
    rst = 1'b1; req = 4'b0; wr = 4'b0;
    tick();
    rst = 1'b0;
    chk("rw_reset_outputs", {grant, valid, count_pointer, done}, 0);
    chk("rw_reset_occ", {occ, empty}, 6'b000001);

    tick(); tick(); tick();
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
